// File: rtl/data_memory_pkg.sv
// ---------------------------------------------------------------------------
// data_memory_pkg
// Shared definitions for the data memory controller slice.
//   state_t   : controller FSM states (INIT fills memory, READY serves requests)
//   INIT_ZERO : init pattern where every word is cleared to zero
//   INIT_ADDR : init pattern where word k holds k (truncated/zero-extended)
// ---------------------------------------------------------------------------
package data_memory_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int INIT_ZERO = 0;
  localparam int INIT_ADDR = 1;

endpackage

// File: rtl/dm_ram_sp.sv
// ---------------------------------------------------------------------------
// dm_ram_sp
// Single-port word memory with synchronous write and a registered read port.
// The read register holds its value between reads and clears on reset; the
// array itself carries no reset so it can map onto block RAM.
// Ports:
//   clk    - clock, all updates on the rising edge
//   reset  - synchronous active-high, clears the read register only
//   we     - write enable, wdata stored at addr
//   re     - read enable, mem[addr] loaded into rdata
//   addr   - word address (AB bits)
//   wdata  - write data (DB bits)
//   rdata  - registered read data (DB bits)
// ---------------------------------------------------------------------------
module dm_ram_sp #(
  parameter int AB = 11,
  parameter int DB = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic          re,
  input  logic [AB-1:0] addr,
  input  logic [DB-1:0] wdata,
  output logic [DB-1:0] rdata
);

  localparam int DEPTH = 1 << AB;

  logic [DB-1:0] mem [0:DEPTH-1];

  // Storage array: plain synchronous write, kept free of reset so synthesis
  // can infer a RAM macro.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Read register: loads only on a read so the last result stays visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// ---------------------------------------------------------------------------
// data_memory_ctrl
// Data memory front end. After reset it walks the whole array writing an
// init pattern (Busy high, requests dropped with a Req_Drop pulse), then
// serves single-cycle writes and 1-cycle-latency reads. Write wins when
// RdRam and WrRam are both asserted.
// Ports:
//   clk      - clock, all state changes on the rising edge
//   reset    - synchronous active-high, restarts the init sequence
//   RdRam    - read request
//   WrRam    - write request
//   Addr     - word address (AB bits)
//   In_Data  - write data (DB bits)
//   Out_Data - registered read data, held between reads
//   Rd_Valid - one-cycle pulse when Out_Data carries a new read result
//   Busy     - high while the init sequence runs
//   Req_Drop - one-cycle pulse when a request arrives while Busy
// ---------------------------------------------------------------------------
module data_memory_ctrl
  import data_memory_pkg::*;
#(
  parameter int AB        = 11,
  parameter int DB        = 16,
  parameter int INIT_MODE = INIT_ADDR
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          RdRam,
  input  logic          WrRam,
  input  logic [AB-1:0] Addr,
  input  logic [DB-1:0] In_Data,
  output logic [DB-1:0] Out_Data,
  output logic          Rd_Valid,
  output logic          Busy,
  output logic          Req_Drop
);

  localparam int DEPTH = 1 << AB;
  localparam logic [AB-1:0] LAST_ADDR = AB'(DEPTH - 1);

  state_t        state;
  state_t        next_state;
  logic [AB-1:0] counter;
  logic [DB-1:0] init_val;
  logic          ram_we;
  logic          ram_re;
  logic [AB-1:0] ram_addr;
  logic [DB-1:0] ram_wdata;

  // State register: reset always lands in INIT regardless of the current
  // state, which is what lets a mid-operation reset restart the fill.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: leave INIT on the edge that writes the last word.
  always_comb begin
    next_state = state;
    case (state)
      INIT:    if (counter == LAST_ADDR) next_state = READY;
      READY:   next_state = READY;
      default: next_state = INIT;
    endcase
  end

  // Init pattern for the word the counter currently points at.
  always_comb begin
    init_val = '0;
    if (INIT_MODE == INIT_ADDR) begin
      init_val = DB'(counter);
    end
  end

  // Output/steering logic: in INIT the RAM port belongs to the fill counter,
  // in READY to the requester. Nothing touches the RAM on a reset edge so an
  // access in flight is aborted cleanly.
  always_comb begin
    Busy      = (state == INIT);
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = Addr;
    ram_wdata = In_Data;
    if (!reset) begin
      if (state == INIT) begin
        ram_we    = 1'b1;
        ram_addr  = counter;
        ram_wdata = init_val;
      end else begin
        ram_we = WrRam;
        ram_re = RdRam && !WrRam;
      end
    end
  end

  // Init counter and handshake pulses. Pulses are recomputed every edge so
  // they naturally last exactly one cycle; a reset edge discards requests
  // without flagging them as dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      counter  <= '0;
      Rd_Valid <= 1'b0;
      Req_Drop <= 1'b0;
    end else begin
      Rd_Valid <= ram_re;
      Req_Drop <= (state == INIT) && (RdRam || WrRam);
      if (state == INIT) begin
        counter <= counter + AB'(1);
      end
    end
  end

  dm_ram_sp #(
    .AB (AB),
    .DB (DB)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (Out_Data)
  );

endmodule

// File: doc/data_memory_ctrl.md
DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

Interface
REQ-001 The block SHALL provide parameter AB, default 11, giving the address width in bits; depth DEPTH = 2**AB words.
REQ-002 The block SHALL provide parameter DB, default 16, giving the data word width in bits.
REQ-003 The block SHALL provide parameter INIT_MODE, default 1, selecting the init pattern: 0 = all words zero; 1 = word k holds k.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port RdRam, input, 1 bit: read request, sampled each edge.
REQ-007 The block SHALL have port WrRam, input, 1 bit: write request, sampled each edge.
REQ-008 The block SHALL have port Addr, input, AB bits: word address for read or write.
REQ-009 The block SHALL have port In_Data, input, DB bits: write data.
REQ-010 The block SHALL have port Out_Data, output, DB bits: registered read data, held between reads.
REQ-011 The block SHALL have port Rd_Valid, output, 1 bit: one-cycle pulse marking new Out_Data.
REQ-012 The block SHALL have port Busy, output, 1 bit: high while the init sequence runs; requests are not accepted.
REQ-013 The block SHALL have port Req_Drop, output, 1 bit: one-cycle pulse when a request is sampled while Busy=1.

Function
REQ-014 The FSM SHALL have two states: INIT and READY; reset high at any edge SHALL force INIT with init counter = 0.
REQ-015 In INIT, each edge with reset low SHALL write the init value for the counter to Mem[counter] and increment the counter; the edge writing Mem[DEPTH-1] SHALL move to READY.
REQ-016 The init value SHALL be 0 when INIT_MODE=0, or counter truncated/zero-extended to DB bits when INIT_MODE=1.
REQ-017 Busy SHALL be 1 in INIT and 0 in READY; after reset release, Busy SHALL stay high for exactly DEPTH edges.
REQ-018 In READY, an edge with WrRam=1 SHALL write In_Data to Mem[Addr].
REQ-019 In READY, an edge with RdRam=1 and WrRam=0 SHALL load Mem[Addr] into Out_Data and set Rd_Valid=1 for that following cycle (1-cycle latency).
REQ-020 When RdRam=1 and WrRam=1 together, the write SHALL take priority; no read occurs, Rd_Valid stays 0 and Out_Data holds.
REQ-021 A read at the edge after a write to the same address SHALL return the newly written data.
REQ-022 Any RdRam or WrRam sampled in INIT SHALL be ignored (no memory change, Out_Data holds) and SHALL pulse Req_Drop for one cycle.
REQ-023 Rd_Valid and Req_Drop SHALL be 0 on every edge that does not meet their set condition.
REQ-024 All AB-bit addresses SHALL be valid; no out-of-range condition exists.

Reset
REQ-025 At an edge with reset=1: state=INIT, counter=0, Out_Data=0, Rd_Valid=0, Req_Drop=0, Busy=1.
REQ-026 Reset asserted mid-init or mid-operation SHALL abort the current access and restart the full init sequence; requests sampled with reset=1 SHALL be discarded without a Req_Drop pulse.

Structure
REQ-027 A shared package data_memory_pkg SHALL hold the FSM state type (INIT, READY) and the INIT_ZERO/INIT_ADDR mode constants.
REQ-028 Storage SHALL be a sub-module dm_ram_sp: single-port, synchronous write, registered read, parametrised by AB/DB. The FSM, init counter and handshake logic SHALL live in data_memory_ctrl.

Verification
REQ-029 AB=4, INIT_MODE=1: release reset -> Busy high exactly 16 cycles; then a read of Addr 5 gives Out_Data=5 and a single Rd_Valid pulse one cycle later.
REQ-030 Write 0xBEEF to Addr 3, then read Addr 3 on the next cycle -> Out_Data=0xBEEF with Rd_Valid one cycle after the read.
REQ-031 RdRam=WrRam=1, Addr 7, In_Data 0x1234 -> Rd_Valid=0 and Out_Data unchanged; a later read of Addr 7 gives 0x1234.
REQ-032 A write of 0xAAAA to Addr 2 while Busy=1 -> Req_Drop pulses once; after init, a read of Addr 2 gives 2.
REQ-033 Write 0xBEEF to Addr 3, then pulse reset for one cycle -> Out_Data=0, Busy high for DEPTH cycles; afterwards Addr 3 reads 3.
REQ-034 AB=10, DB=8, INIT_MODE=1: a read of Addr 0x1FF gives 0xFF (truncation); INIT_MODE=0 gives 0x00.
